// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Drives one time-multiplexed six-digit 7-segment display from the clock's
//   six parallel digit codes. All six codes are captured once per frame so a
//   frame never mixes old and new digits. Each digit slot opens with a short
//   all-dark interval that suppresses ghosting. The whole display flashes
//   while the alarm flag is high.
//
// Parameters
//   CLOCKS_PER_DIGIT  clocks per digit slot (>= 2)
//   BLANK_CLOCKS      dark clocks at the start of each slot (1 .. CLOCKS_PER_DIGIT-1)
//   BLINK_BITS        frame counter width; with alarm high the display is dark
//                     while the counter MSB is 1
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   seg_hh..sl   six digit codes, hh = leftmost digit
//   alarm        alarm ringing flag (clk domain)
//   seg_out      shared segment bus, active-high
//   dp           separator dot, lit on digits 1 and 3
//   digit_sel    one-hot digit enable, bit0 = hh .. bit5 = sl
//   frame_start  high during the first clock of every frame

module seg_scan_driver #(
  parameter int CLOCKS_PER_DIGIT = 4,
  parameter int BLANK_CLOCKS     = 1,
  parameter int BLINK_BITS       = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] seg_hh,
  input  logic [6:0] seg_hl,
  input  logic [6:0] seg_mh,
  input  logic [6:0] seg_ml,
  input  logic [6:0] seg_sh,
  input  logic [6:0] seg_sl,
  input  logic       alarm,
  output logic [6:0] seg_out,
  output logic       dp,
  output logic [5:0] digit_sel,
  output logic       frame_start
);

  localparam int CW = $clog2(CLOCKS_PER_DIGIT);

  logic [CW-1:0]         cnt, cnt_next;
  logic [2:0]            idx, idx_next;
  logic [BLINK_BITS-1:0] frame_cnt, frame_next;
  logic                  running;
  logic [6:0]            snap [6];
  logic [6:0]            snap_next [6];
  logic [6:0]            codes_in [6];
  logic                  capture;
  logic                  lit_next;
  logic [6:0]            seg_next;
  logic                  dp_next;
  logic [5:0]            sel_next;
  logic                  fs_next;

  assign codes_in[0] = seg_hh;
  assign codes_in[1] = seg_hl;
  assign codes_in[2] = seg_mh;
  assign codes_in[3] = seg_ml;
  assign codes_in[4] = seg_sh;
  assign codes_in[5] = seg_sl;

  // The slot (0,0) is where the next frame's digits are captured.
  assign capture = (cnt == '0) && (idx == 3'd0);

  // Scan position advance. The clock after reset release does not advance:
  // it re-enters slot (0,0) as a genuine frame start, so the first frame
  // after reset is full length and is flagged by frame_start.
  always_comb begin
    cnt_next   = cnt;
    idx_next   = idx;
    frame_next = frame_cnt;
    if (!running) begin
      cnt_next = '0;
      idx_next = 3'd0;
    end else if (cnt == CW'(CLOCKS_PER_DIGIT - 1)) begin
      cnt_next = '0;
      if (idx == 3'd5) begin
        idx_next   = 3'd0;
        frame_next = frame_cnt + 1'b1;
      end else begin
        idx_next = idx + 3'd1;
      end
    end else begin
      cnt_next = cnt + 1'b1;
    end
  end

  // The snapshot is taken at the end of the capture slot. Outputs are fed
  // from the post-edge snapshot so the first lit clock of digit 0 already
  // sees the freshly captured code when BLANK_CLOCKS is 1.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      snap_next[i] = capture ? codes_in[i] : snap[i];
    end
  end

  // Outputs are derived from the next scan position so that the registered
  // outputs line up with the position held in the same cycle.
  always_comb begin
    lit_next = (cnt_next >= CW'(BLANK_CLOCKS)) &&
               !(alarm && frame_next[BLINK_BITS-1]);
    seg_next = 7'd0;
    dp_next  = 1'b0;
    sel_next = 6'd0;
    if (lit_next) begin
      seg_next = snap_next[idx_next];
      dp_next  = (idx_next == 3'd1) || (idx_next == 3'd3);
      sel_next = 6'd1 << idx_next;
    end
    fs_next = (cnt_next == '0) && (idx_next == 3'd0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      idx         <= 3'd0;
      frame_cnt   <= '0;
      running     <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        snap[i] <= 7'd0;
      end
      seg_out     <= 7'd0;
      dp          <= 1'b0;
      digit_sel   <= 6'd0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      idx         <= idx_next;
      frame_cnt   <= frame_next;
      running     <= 1'b1;
      for (int i = 0; i < 6; i++) begin
        snap[i] <= snap_next[i];
      end
      seg_out     <= seg_next;
      dp          <= dp_next;
      digit_sel   <= sel_next;
      frame_start <= fs_next;
    end
  end

endmodule
